// File: rtl/score_keeper_if.sv
// Score/night-mode bundle between the game core and the display/sound consumers.
// The master side (score_keeper) takes start/crash and drives score and night state.
interface score_keeper_if;
    logic        start;
    logic        crash;
    logic [13:0] game_score;
    logic        running;
    logic        game_over;
    logic        dark;
    logic        dark_start;
    logic        dark_end;
    logic        milestone;

    modport master (
        input  start, crash,
        output game_score, running, game_over, dark, dark_start, dark_end, milestone
    );

    modport slave (
        output start, crash,
        input  game_score, running, game_over, dark, dark_start, dark_end, milestone
    );
endinterface

// File: rtl/score_keeper.sv
// Game score counter with IDLE/RUN/OVER control, day/night level and event pulses.
// Every output is a flop; pulses are produced only on the cycle the score changes.
module score_keeper #(
    parameter int unsigned TICK_CYCLES = 2500000,
    parameter int unsigned SCORE_MAX   = 9999,
    parameter int unsigned DARK_PERIOD = 700,
    parameter int unsigned DARK_LEN    = 150,
    parameter int unsigned MILESTONE   = 100
) (
    input logic           clk,
    input logic           rst,
    score_keeper_if.master bus
);

    localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned PW = (DARK_PERIOD > 1) ? $clog2(DARK_PERIOD) : 1;
    localparam int unsigned MW = (MILESTONE > 1) ? $clog2(MILESTONE) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StOver} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [13:0]   score_q, score_d;
    logic [13:0]   base_q, base_d;
    logic [PW-1:0] per_q, per_d;
    logic [MW-1:0] ms_q, ms_d;
    logic          dark_q, dark_d;
    logic          ds_q, ds_d;
    logic          de_q, de_d;
    logic          mil_q, mil_d;
    logic          run_q, run_d;
    logic          over_q, over_d;

    logic          tick_wrap, per_wrap, ms_wrap, do_inc;
    logic [14:0]   dark_end_score;

    assign tick_wrap      = (tick_q == TW'(TICK_CYCLES - 1));
    assign per_wrap       = (per_q == PW'(DARK_PERIOD - 1));
    assign ms_wrap        = (ms_q == MW'(MILESTONE - 1));
    // One extra bit so base+DARK_LEN beyond the score range simply never matches.
    assign dark_end_score = {1'b0, base_q} + 15'(DARK_LEN);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        score_d = score_q;
        base_d  = base_q;
        per_d   = per_q;
        ms_d    = ms_q;
        dark_d  = dark_q;
        ds_d    = 1'b0;
        de_d    = 1'b0;
        mil_d   = 1'b0;
        do_inc  = 1'b0;

        unique case (state_q)
            StIdle, StOver: begin
                if (bus.start) begin
                    state_d = StRun;
                    tick_d  = '0;
                    score_d = '0;
                    base_d  = '0;
                    per_d   = '0;
                    ms_d    = '0;
                    dark_d  = 1'b0;
                end
            end
            StRun: begin
                if (bus.crash) begin
                    state_d = StOver;
                end else begin
                    tick_d = tick_wrap ? '0 : tick_q + TW'(1);
                    do_inc = tick_wrap && (score_q != 14'(SCORE_MAX));
                end
            end
            default: state_d = StIdle;
        endcase

        // Sub-counters track the score modulo each period, so a wrap marks a new multiple.
        if (do_inc) begin
            score_d = score_q + 14'd1;
            per_d   = per_wrap ? '0 : per_q + PW'(1);
            ms_d    = ms_wrap ? '0 : ms_q + MW'(1);
            mil_d   = ms_wrap;
            if (dark_q) begin
                if ({1'b0, score_d} == dark_end_score) begin
                    dark_d = 1'b0;
                    de_d   = 1'b1;
                end
            end else if (per_wrap) begin
                dark_d = 1'b1;
                ds_d   = 1'b1;
                base_d = score_d;
            end
        end

        run_d  = (state_d == StRun);
        over_d = (state_d == StOver);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            tick_q  <= '0;
            score_q <= '0;
            base_q  <= '0;
            per_q   <= '0;
            ms_q    <= '0;
            dark_q  <= 1'b0;
            ds_q    <= 1'b0;
            de_q    <= 1'b0;
            mil_q   <= 1'b0;
            run_q   <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            score_q <= score_d;
            base_q  <= base_d;
            per_q   <= per_d;
            ms_q    <= ms_d;
            dark_q  <= dark_d;
            ds_q    <= ds_d;
            de_q    <= de_d;
            mil_q   <= mil_d;
            run_q   <= run_d;
            over_q  <= over_d;
        end
    end

    assign bus.game_score = score_q;
    assign bus.running    = run_q;
    assign bus.game_over  = over_q;
    assign bus.dark       = dark_q;
    assign bus.dark_start = ds_q;
    assign bus.dark_end   = de_q;
    assign bus.milestone  = mil_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed scenarios plus random start/crash traffic,
// every cycle compared against an arithmetic reference model.
module tb_score_keeper;

    logic clk;
    logic rst;
    logic chk_en;
    int   n_tests;
    int   n_fail;

    score_keeper_if ia ();
    score_keeper_if ib ();

    score_keeper #(
        .TICK_CYCLES(4)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(ia)
    );

    score_keeper #(
        .TICK_CYCLES(2),
        .SCORE_MAX  (20),
        .DARK_PERIOD(10),
        .DARK_LEN   (15),
        .MILESTONE  (100)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int state;  // 0 idle, 1 run, 2 over
        int score;
        int tick;
        bit dark;
        int base;
        bit ds;
        bit de;
        bit ms;
    } model_t;

    model_t ma, mb;

    function automatic model_t step(model_t m, bit st, bit cr, int t, int smax, int dp,
                                    int dl, int mst);
        model_t n = m;
        n.ds = 0;
        n.de = 0;
        n.ms = 0;
        if (m.state != 1) begin
            if (st) begin
                n = '{default: 0};
                n.state = 1;
            end
        end else if (cr) begin
            n.state = 2;
        end else begin
            n.tick = (m.tick + 1) % t;
            if (m.tick == t - 1 && m.score < smax) begin
                n.score = m.score + 1;
                n.ms = (n.score % mst == 0);
                if (m.dark) begin
                    if (n.score == m.base + dl) begin
                        n.dark = 0;
                        n.de = 1;
                    end
                end else if (n.score % dp == 0) begin
                    n.dark = 1;
                    n.ds = 1;
                    n.base = n.score;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] exp_flags(model_t m);
        return {26'd0, m.state == 1, m.state == 2, m.dark, m.ds, m.de, m.ms};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= '{default: 0};
            mb <= '{default: 0};
        end else begin
            ma <= step(ma, ia.start, ia.crash, 4, 9999, 700, 150, 100);
            mb <= step(mb, ib.start, ib.crash, 2, 20, 10, 15, 100);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flags_a();
        return {26'd0, ia.running, ia.game_over, ia.dark, ia.dark_start, ia.dark_end,
                ia.milestone};
    endfunction

    function automatic logic [31:0] flags_b();
        return {26'd0, ib.running, ib.game_over, ib.dark, ib.dark_start, ib.dark_end,
                ib.milestone};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("a_score", 32'(ia.game_score), 32'(ma.score));
            check_eq("a_flags", flags_a(), exp_flags(ma));
            check_eq("b_score", 32'(ib.game_score), 32'(mb.score));
            check_eq("b_flags", flags_b(), exp_flags(mb));
        end
    end

    task automatic pulse_a(input bit s, input bit c);
        ia.start = s;
        ia.crash = c;
        @(negedge clk);
        ia.start = 1'b0;
        ia.crash = 1'b0;
    endtask

    task automatic run_a(input int target, input int phase);
        for (int i = 0; i < 6000; i++) begin
            if (32'(ia.game_score) == target && (phase < 0 || ma.tick == phase)) break;
            @(negedge clk);
        end
        check_eq("reach", 32'(ia.game_score), target);
    endtask

    initial begin
        int ms_n, ds_n, de_n, ds_sc, de_sc;
        n_tests  = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        ia.start = 1'b0;
        ia.crash = 1'b0;
        ib.start = 1'b0;
        ib.crash = 1'b0;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("reset_a", {18'd0, ia.game_score} | flags_a(), 0);
        check_eq("reset_b", {18'd0, ib.game_score} | flags_b(), 0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Start latency and tick rate
        pulse_a(1'b1, 1'b0);
        check_eq("t1_running", 32'(ia.running), 1);
        check_eq("t1_score0", 32'(ia.game_score), 0);
        repeat (4) @(negedge clk);
        check_eq("t1_score1", 32'(ia.game_score), 1);
        repeat (36) @(negedge clk);
        check_eq("t1_score10", 32'(ia.game_score), 10);

        // Milestones and one full night
        ms_n  = 0;
        ds_n  = 0;
        de_n  = 0;
        ds_sc = -1;
        de_sc = -1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (ia.milestone) ms_n++;
            if (ia.dark_start) begin
                ds_n++;
                ds_sc = 32'(ia.game_score);
                check_eq("t2_dark_on", 32'(ia.dark), 1);
            end
            if (ia.dark_end) begin
                de_n++;
                de_sc = 32'(ia.game_score);
            end
            if (ia.game_score == 14'd850) break;
        end
        check_eq("t2_score", 32'(ia.game_score), 850);
        check_eq("t2_milestones", ms_n, 8);
        check_eq("t2_dark_starts", ds_n, 1);
        check_eq("t2_dark_ends", de_n, 1);
        check_eq("t2_start_at", ds_sc, 700);
        check_eq("t2_end_at", de_sc, 850);
        check_eq("t2_dark_off", 32'(ia.dark), 0);

        // Crash coincident with a tick at 42
        pulse_a(1'b0, 1'b1);
        pulse_a(1'b1, 1'b0);
        run_a(42, 3);
        pulse_a(1'b0, 1'b1);
        check_eq("t3_over", 32'(ia.game_over), 1);
        check_eq("t3_score", 32'(ia.game_score), 42);
        repeat (20) @(negedge clk);
        check_eq("t3_frozen", 32'(ia.game_score), 42);
        pulse_a(1'b1, 1'b1);
        check_eq("t3_restart", {18'd0, ia.game_score, ia.dark, ia.dark_end}, 0);
        check_eq("t3_running", 32'(ia.running), 1);

        // Crash during night, restart clears dark silently
        run_a(760, -1);
        check_eq("t4_dark", 32'(ia.dark), 1);
        pulse_a(1'b0, 1'b1);
        pulse_a(1'b1, 1'b0);
        check_eq("t4_cleared", {30'd0, ia.dark, ia.dark_end}, 0);
        ds_sc = -1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (ia.dark_start) begin
                ds_sc = 32'(ia.game_score);
                break;
            end
        end
        check_eq("t4_next_night", ds_sc, 700);

        // Saturation with a night that cannot finish
        ib.start = 1'b1;
        @(negedge clk);
        ib.start = 1'b0;
        ds_sc = -1;
        for (int i = 0; i < 200; i++) begin
            if (ib.dark_start) ds_sc = 32'(ib.game_score);
            if (ib.game_score == 14'd20) break;
            @(negedge clk);
        end
        check_eq("t5_dark_at", ds_sc, 10);
        repeat (200) @(negedge clk);
        check_eq("t5_hold", 32'(ib.game_score), 20);
        check_eq("t5_dark", 32'(ib.dark), 1);
        check_eq("t5_running", 32'(ib.running), 1);

        // Asynchronous reset mid-game
        pulse_a(1'b0, 1'b1);
        pulse_a(1'b1, 1'b0);
        run_a(333, -1);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_async_a", {18'd0, ia.game_score} | flags_a(), 0);
        check_eq("t6_async_b", {18'd0, ib.game_score} | flags_b(), 0);
        @(negedge clk);
        rst = 1'b0;
        pulse_a(1'b1, 1'b0);
        check_eq("t6_running", 32'(ia.running), 1);
        check_eq("t6_score", 32'(ia.game_score), 0);
        repeat (4) @(negedge clk);
        check_eq("t6_score1", 32'(ia.game_score), 1);

        // Random start/crash traffic on both instances
        for (int i = 0; i < 30000; i++) begin
            ia.start = ($urandom_range(0, 299) == 0);
            ia.crash = ($urandom_range(0, 3999) == 0);
            ib.start = ($urandom_range(0, 49) == 0);
            ib.crash = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        ia.start = 1'b0;
        ia.crash = 1'b0;
        ib.start = 1'b0;
        ib.crash = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Producer side of the score/night-mode interface.
- Runs the game score counter and generates the day/night level plus its event pulses.
- Its outputs drive the colour-inversion post-processor, the score display and the sound logic.
- Sits in the game core clock domain, between the game FSM (start/crash) and the display path.

Parameters:
- TICK_CYCLES, 2500000: clk cycles per score point while running.
- SCORE_MAX, 9999: saturation value of game_score; must be below 2^14.
- DARK_PERIOD, 700: night starts when the score reaches a nonzero multiple of this value.
- DARK_LEN, 150: night ends this many points after it started.
- MILESTONE, 100: a milestone pulse fires at each nonzero multiple of this value.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: one-cycle request to begin or restart a game.
- crash, input, 1: one-cycle collision event.
- game_score, output, 14: current score, binary, registered.
- running, output, 1: high while in state RUN.
- game_over, output, 1: high while in state OVER.
- dark, output, 1: night-mode level.
- dark_start, output, 1: one-cycle pulse when dark rises.
- dark_end, output, 1: one-cycle pulse when dark falls through normal expiry.
- milestone, output, 1: one-cycle pulse.

Behaviour:
- Reset (asynchronous, any time, including mid-game):
  - State goes to IDLE.
  - game_score, tick counter and all internal sub-counters go to 0.
  - All outputs go to 0.
- All outputs are registered.
- States are IDLE, RUN and OVER.
- IDLE:
  - start=1 → RUN next cycle.
  - game_score=0, tick counter=0, dark=0.
- RUN:
  - The tick counter counts 0..TICK_CYCLES-1 and then wraps.
  - On the wrap cycle, game_score increments by 1. The new value is visible on the following cycle.
  - At game_score==SCORE_MAX the increment is suppressed and the score holds. The state stays in RUN.
  - crash=1 → OVER next cycle. Crash beats a coincident tick: no increment occurs.
  - start is ignored in RUN.
- OVER:
  - game_score, dark and the tick counter are frozen.
  - crash is ignored.
  - start=1 → RUN next cycle. game_score, tick counter, dark and sub-counters all clear to 0.
  - No dark_end pulse is produced on this clear.
- Simultaneous start and crash: crash takes effect in RUN; start takes effect in IDLE/OVER.
- Night start:
  - Triggered in the same cycle game_score takes a new nonzero multiple of DARK_PERIOD while dark=0.
  - dark goes 1, dark_start pulses for exactly one cycle, and the base score is latched.
- Night end:
  - Triggered in the cycle game_score reaches base+DARK_LEN while dark=1.
  - dark goes 0 and dark_end pulses for one cycle.
  - If SCORE_MAX stops the score first, dark stays 1 until restart or reset.
- A multiple of DARK_PERIOD reached while dark=1 is ignored (no retrigger).
- Milestone: milestone pulses one cycle when game_score takes a new nonzero multiple of MILESTONE.
- Pulses fire only on score changes. A held score never re-pulses.
- Multiples are tracked with wrap-around sub-counters that advance with each increment; no runtime divider or modulo operator is used.
- game_score never exceeds SCORE_MAX and never wraps.

Test Plan (TICK_CYCLES=4 unless noted):
1. start pulse at cycle 0 → running=1 from cycle 1; game_score=1 after 4 RUN cycles; game_score=10 after 40 RUN cycles.
2. Run to 850 → milestone pulses at 100,200,…,800 (8 pulses); dark_start and dark=1 on the cycle score=700; dark_end and dark=0 on the cycle score=850; no other dark pulses.
3. crash on the same cycle as a tick at score=42 → game_over=1, score stays 42 for 20 further cycles; then start → score=0, dark=0, running=1, no dark_end pulse.
4. crash at score=760 (dark=1), then start → dark clears to 0 with no dark_end pulse; the next night begins at 700.
5. SCORE_MAX=20, DARK_PERIOD=10, DARK_LEN=15 → dark rises at score 10; score holds at 20; dark remains 1 after 100 further ticks; running remains 1.
6. Assert rst mid-RUN at score=333 → all outputs 0 immediately, without waiting for a clock edge; after release, start restarts cleanly from 0.
